ifetch_stage: RTL and testbench
===============================

// Module: ifetch_stage
// PURPOSE
//  Instruction fetch stage plus IF/ID pipeline register. Generates the PC and issues one
//  outstanding request at a time on a valid/ready instruction-memory port. It registers the
//  returned word into IF/ID; if_id_inst directly drives the decode-stage immediate generator's inst_code.
//  Supports decode stalls (hold) and branch/jump redirects (flush, with drop of in-flight fetch).
// PARAMETERS
//  XLEN      32            data/address width
//  RESET_PC  32'h0000_0000 first fetch address after reset
//  NOP_INST  32'h0000_0013 bubble encoding (addi x0,x0,0) loaded on reset/flush
// PORTS
//  clk             in   1     rising-edge clock
//  reset_n         in   1     asynchronous, active-low reset
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request this cycle
//  imem_addr       out  XLEN  fetch address (= pc), bits[1:0]=0
//  imem_rsp_valid  in   1     instruction word returned (>=1 cycle after accept)
//  imem_rsp_data   in   32    instruction word
//  stall_id        in   1     decode cannot accept; IF/ID must hold
//  flush_if        in   1     redirect from EX (taken branch/JAL/JALR)
//  redirect_pc     in   XLEN  target address; bits[1:0] forced to 0
//  if_id_valid     out  1     IF/ID holds a real instruction
//  if_id_pc        out  XLEN  PC of if_id_inst
//  if_id_pc4       out  XLEN  if_id_pc + 4 (JAL/JALR link value)
//  if_id_inst      out  32    instruction to decode / immediate generator
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, state=S_REQ, if_id_valid=0, if_id_inst=NOP_INST,
//   if_id_pc=0, if_id_pc4=4, skid empty. imem_req_valid=0 while reset_n=0.
//  States: S_REQ, S_WAIT, S_HOLD, S_DROP. imem_req_valid=1 only in S_REQ. imem_addr=pc.
//  The request is accepted when valid&&ready. At most one request is outstanding.
//  S_REQ : accept -> req_pc<=pc, S_WAIT.
//  S_WAIT: rsp_valid && slot_free -> load IF/ID {1,req_pc,req_pc+4,data}, pc<=req_pc+4, S_REQ.
//          rsp_valid && !slot_free -> capture word in skid reg, S_HOLD.
//  S_HOLD: slot_free -> load IF/ID from skid, pc<=req_pc+4, S_REQ.
//  S_DROP: rsp_valid -> discard word, S_REQ.
//  slot_free = !stall_id || !if_id_valid. If IF/ID is consumed (!stall_id) with nothing new,
//   then if_id_valid<=0 and if_id_inst<=NOP_INST.
//  Fetch latency: accept->rsp N cycles; if_id_valid rises the cycle after rsp_valid. The next
//   request is issued in the cycle after the load. Max throughput is 1 instr per 2 cycles at zero-wait memory.
//  flush_if has priority over stall_id and every other event in the same cycle:
//   pc<=redirect_pc&~3; if_id_valid<=0; if_id_inst<=NOP_INST; skid cleared.
//   S_REQ with accept same cycle -> S_DROP; S_REQ without accept -> S_REQ (new addr next cycle).
//   S_WAIT without rsp -> S_DROP; S_WAIT with rsp same cycle -> discard, S_REQ.
//   S_HOLD -> S_REQ; S_DROP -> stays S_DROP (pc updated).
//  A word arriving while flush_if=1 is never written to IF/ID.
//  pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0). No exception is raised.
//  imem_rsp_valid is ignored in S_REQ (protocol violation, SVA assertion).
//  imem_addr is stable while imem_req_valid && !imem_req_ready (SVA assertion).
//  Reset mid-fetch: all state cleared; any response after release is ignored until a new request is accepted.
// STRUCTURE
//  riscv_pkg: NOP_INST constant, fetch_state_e enum {S_REQ,S_WAIT,S_HOLD,S_DROP},
//   XLEN, opcode localparams shared with decode/imm generation.
//  Sub-module if_id_reg: IF/ID register with load/hold/flush controls, NOP reset. The FSM, pc and skid stay in ifetch_stage.
// TESTING
//  1 reset, ready=1, 1-cycle memory returning 32'h00500093 -> addr 0, then if_id {1,pc 0,pc4 4,inst 00500093}, next addr 4.
//  2 stall_id=1 for 3 cycles while word at pc 8 returns -> S_HOLD, IF/ID holds pc 4. On release, IF/ID=pc 8, next addr 12.
//  3 flush_if, redirect_pc=32'h100, in S_WAIT with rsp 2 cycles later -> word dropped, if_id_valid=0,
//    next request addr 32'h100.
//  4 flush_if same cycle as rsp_valid and as stall_id=1 -> word discarded, IF/ID=NOP/valid 0, addr 0x100.
//  5 redirect_pc=32'h203 -> fetch addr 32'h200; pc 32'hFFFF_FFFC fetch -> next addr 32'h0.
//  6 reset_n pulsed low while in S_WAIT -> outputs at reset values immediately; late rsp ignored; first addr RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: widths, bubble encoding, fetch FSM states
// and the opcodes the decode/immediate logic keys on.
package riscv_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats load beats consume; an empty slot
// always carries the bubble encoding so decode never sees stale bits.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int          XLEN     = riscv_pkg::XLEN,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_load,
  input  logic            i_consume,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc4,
  output logic [31:0]     o_inst
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc4;
  logic [31:0]     r_inst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_pc4   <= XLEN'(4);
      r_inst  <= NOP_INST;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_pc4   <= i_pc + XLEN'(4);
      r_inst  <= i_inst;
    end else if (i_consume) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
  assign o_inst  = r_inst;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch: PC, single-outstanding valid/ready memory request, a
// one-word skid for responses that arrive while decode is stalled, and IF/ID.
module ifetch_stage
  import riscv_pkg::*;
#(
  parameter int             XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]    NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            stall_id,
  input  logic            flush_if,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [31:0]     if_id_inst
);

  fetch_state_e    r_state, w_state_next;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic [XLEN-1:0] r_req_pc, w_req_pc_next;
  logic [31:0]     r_skid, w_skid_next;
  logic            w_accept, w_slot_free, w_load;
  logic [31:0]     w_load_inst;
  logic [XLEN-1:0] w_req_pc4;

  // Request is masked during reset even though the state already reads S_REQ.
  assign imem_req_valid = reset_n && (r_state == S_REQ);
  assign imem_addr      = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_slot_free    = !stall_id || !if_id_valid;
  assign w_req_pc4      = r_req_pc + XLEN'(4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_skid   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_req_pc <= w_req_pc_next;
      r_skid   <= w_skid_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_req_pc_next = r_req_pc;
    w_skid_next   = r_skid;
    w_load        = 1'b0;
    w_load_inst   = imem_rsp_data;
    if (flush_if) begin
      w_pc_next   = {redirect_pc[XLEN-1:2], 2'b00};
      w_skid_next = '0;
      // A response landing in the flush cycle retires the outstanding request.
      case (r_state)
        S_REQ:         w_state_next = w_accept ? S_DROP : S_REQ;
        S_WAIT, S_DROP: w_state_next = imem_rsp_valid ? S_REQ : S_DROP;
        default:       w_state_next = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: if (w_accept) begin
          w_req_pc_next = r_pc;
          w_state_next  = S_WAIT;
        end
        S_WAIT: if (imem_rsp_valid) begin
          if (w_slot_free) begin
            w_load       = 1'b1;
            w_pc_next    = w_req_pc4;
            w_state_next = S_REQ;
          end else begin
            w_skid_next  = imem_rsp_data;
            w_state_next = S_HOLD;
          end
        end
        S_HOLD: if (w_slot_free) begin
          w_load       = 1'b1;
          w_load_inst  = r_skid;
          w_pc_next    = w_req_pc4;
          w_state_next = S_REQ;
        end
        default: if (imem_rsp_valid) w_state_next = S_REQ;
      endcase
    end
  end

  if_id_reg #(.XLEN(XLEN), .NOP_INST(NOP_INST)) u_if_id (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_flush   (flush_if),
    .i_load    (w_load),
    .i_consume (!stall_id),
    .i_pc      (r_req_pc),
    .i_inst    (w_load_inst),
    .o_valid   (if_id_valid),
    .o_pc      (if_id_pc),
    .o_pc4     (if_id_pc4),
    .o_inst    (if_id_inst)
  );

`ifndef SYNTHESIS
  // Responses seen before any request since reset are stale, not violations.
  logic r_armed;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_armed <= 1'b0;
    else if (w_accept) r_armed <= 1'b1;
  end

  a_no_rsp_in_req: assert property (@(posedge clk) disable iff (!reset_n)
    !(r_state == S_REQ && imem_rsp_valid && r_armed));

  a_addr_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (imem_req_valid && !imem_req_ready && !flush_if) |=> $stable(imem_addr));
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed fetch scenarios followed by a randomized run checked against a
// program-order model of what decode should consume.
module tb_ifetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_id, flush_if;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_pc4, if_id_inst;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic        mem_rnd  = 1'b0;
  int          mem_lat  = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_paddr;

  always #5 clk = ~clk;

  ifetch_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall_id       (stall_id),
    .flush_if       (flush_if),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_inst     (if_id_inst)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  // Memory: decides at the falling edge what the next rising edge will see.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (mem_pend) begin
        mem_cnt = mem_cnt - 1;
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(mem_paddr);
          mem_pend       = 1'b0;
        end
      end
      if (reset_n && imem_req_valid && imem_req_ready) begin
        mem_pend  = 1'b1;
        mem_paddr = imem_addr;
        mem_cnt   = mem_rnd ? int'($urandom_range(3, 1)) : mem_lat;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] pc4, input logic [31:0] inst);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'(v));
    chk({tag, "_pc"},    if_id_pc,   pc);
    chk({tag, "_pc4"},   if_id_pc4,  pc4);
    chk({tag, "_inst"},  if_id_inst, inst);
  endtask

  logic [31:0] exp_pc;
  int          consumed;

  initial begin
    reset_n = 1'b0; imem_req_ready = 1'b0; stall_id = 1'b0;
    flush_if = 1'b0; redirect_pc = '0;
    repeat (3) tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk_ifid("rst", 1'b0, 32'h0, 32'h4, NOP);

    // 1: first fetch from reset PC, one-cycle memory
    reset_n = 1'b1; imem_req_ready = 1'b1;
    #1;
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    tick(); tick();
    chk_ifid("t1_ifid", 1'b1, 32'h0, 32'h4, 32'h0050_0093);
    chk("t1_next_addr", imem_addr, 32'h4);

    // 2: decode stall while the word at pc 8 returns
    tick(); tick();
    chk("t2_pc4_loaded", if_id_pc, 32'h4);
    stall_id = 1'b1;
    tick(); tick();
    chk("t2_hold_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t2_hold_pc", if_id_pc, 32'h4);
    tick();
    chk_ifid("t2_still", 1'b1, 32'h4, 32'h8, mem_word(32'h4));
    stall_id = 1'b0;
    tick();
    chk_ifid("t2_release", 1'b1, 32'h8, 32'hC, mem_word(32'h8));
    chk("t2_next_addr", imem_addr, 32'hC);

    // 3: redirect while waiting; the response two cycles later is dropped
    mem_lat = 2;
    tick();
    chk("t3_consumed", 32'(if_id_valid), 32'd0);
    flush_if = 1'b1; redirect_pc = 32'h100;
    tick();
    flush_if = 1'b0;
    chk("t3_drop_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    chk("t3_dropped_valid", 32'(if_id_valid), 32'd0);
    chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t3_addr", imem_addr, 32'h100);

    // 4: flush coincides with response and stall
    mem_lat = 1;
    tick();
    flush_if = 1'b1; stall_id = 1'b1; redirect_pc = 32'h100;
    tick();
    flush_if = 1'b0; stall_id = 1'b0;
    chk("t4_valid", 32'(if_id_valid), 32'd0);
    chk("t4_inst", if_id_inst, NOP);
    chk("t4_addr", imem_addr, 32'h100);

    // 5: redirect alignment and PC wrap
    imem_req_ready = 1'b0; flush_if = 1'b1; redirect_pc = 32'h203;
    tick();
    chk("t5_aligned", imem_addr, 32'h200);
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    chk("t5_top", imem_addr, 32'hFFFF_FFFC);
    flush_if = 1'b0; imem_req_ready = 1'b1;
    tick(); tick();
    chk_ifid("t5_wrap", 1'b1, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC));
    chk("t5_wrap_addr", imem_addr, 32'h0);

    // 6: reset pulse mid-fetch; the late response must be ignored
    mem_lat = 3; stall_id = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
    chk_ifid("t6_rst", 1'b0, 32'h0, 32'h4, NOP);
    tick();
    reset_n = 1'b1; imem_req_ready = 1'b0; stall_id = 1'b0;
    tick(); tick(); tick();
    chk("t6_late_ignored", 32'(if_id_valid), 32'd0);
    chk("t6_req_valid_after", 32'(imem_req_valid), 32'd1);
    chk("t6_addr", imem_addr, 32'h0);
    mem_lat = 1; imem_req_ready = 1'b1;
    tick(); tick();
    chk_ifid("t6_refetch", 1'b1, 32'h0, 32'h4, 32'h0050_0093);

    // Random phase: decode must see words in program order, restarting at each redirect
    mem_rnd  = 1'b1;
    exp_pc   = 32'h0;
    consumed = 0;
    for (int i = 0; i < 800; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      stall_id       = ($urandom_range(2, 0) == 0);
      flush_if       = ($urandom_range(15, 0) == 0);
      redirect_pc    = $urandom;
      if (flush_if) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (if_id_valid && !stall_id) begin
        chk("rnd_pc",   if_id_pc,   exp_pc);
        chk("rnd_pc4",  if_id_pc4,  exp_pc + 32'd4);
        chk("rnd_inst", if_id_inst, mem_word(exp_pc));
        exp_pc   = exp_pc + 32'd4;
        consumed = consumed + 1;
      end
      tick();
    end
    flush_if = 1'b0; stall_id = 1'b0;
    chk("rnd_progress", 32'(consumed >= 40), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
